// File: rtl/imm_alloc.sv
// Row allocator and write sequencer for the 4-wide immediate file.
// Latency: grant and file write enable in the same cycle; released rows are reusable the next cycle.
// Backpressure: o_alloc_ready drops when no row is free or on flush; dispatch holds its request.
// Ports: i_clk/i_rst (sync active-high), i_flush; alloc request (valid, mask) -> ready, row tag,
//        file write enable and one-hot row select; two release ports ({row, slot});
//        o_free_cnt (free rows), o_err (sticky illegal-release flag).
module imm_alloc #(
    parameter int SIZE = 32
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_flush,
    input  logic                            i_alloc_valid,
    input  logic [3:0]                      i_alloc_mask,
    output logic                            o_alloc_ready,
    output logic [$clog2(SIZE/4)-1:0]       o_alloc_row,
    output logic                            o_we,
    output logic [SIZE/4-1:0]               o_waddr,
    input  logic                            i_rel_valid0,
    input  logic                            i_rel_valid1,
    input  logic [$clog2(SIZE)-1:0]         i_rel_addr0,
    input  logic [$clog2(SIZE)-1:0]         i_rel_addr1,
    output logic [$clog2(SIZE/4):0]         o_free_cnt,
    output logic                            o_err
);
    localparam int ROWS = SIZE / 4;
    localparam int RW   = $clog2(ROWS);
    localparam int AW   = $clog2(SIZE);

    logic [ROWS-1:0]      free;
    logic [ROWS-1:0][3:0] live;
    logic [RW:0]          free_cnt;
    logic                 err;

    logic [RW-1:0]        alloc_row;
    logic                 grant;

    logic [1:0]           rel_v;
    logic [RW-1:0]        rel_row [2];
    logic [1:0]           rel_slot [2];
    logic [1:0]           rel_ok;
    logic [1:0]           rel_bad;

    logic [ROWS-1:0]      free_nxt;
    logic [ROWS-1:0][3:0] live_nxt;
    logic [RW:0]          rec_cnt;
    logic [RW:0]          cnt_nxt;

    // Lowest set bit of the free bitmap; scanning downward leaves the lowest index last.
    always_comb begin
        alloc_row = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (free[r]) alloc_row = RW'(r);
        end
    end

    assign o_alloc_ready = (|free) & ~i_flush;
    assign grant         = i_alloc_valid & o_alloc_ready & (i_alloc_mask != 4'b0000);
    assign o_we          = grant;
    assign o_waddr       = grant ? (ROWS'(1) << alloc_row) : '0;
    assign o_alloc_row   = alloc_row;
    assign o_free_cnt    = free_cnt;
    assign o_err         = err;

    // Release legality is judged against pre-edge state, so two ports naming the
    // same live slot both look legal and collapse into a single clear.
    always_comb begin
        rel_v       = {i_rel_valid1, i_rel_valid0};
        rel_row[0]  = i_rel_addr0[AW-1:2];
        rel_row[1]  = i_rel_addr1[AW-1:2];
        rel_slot[0] = i_rel_addr0[1:0];
        rel_slot[1] = i_rel_addr1[1:0];
        rel_ok      = '0;
        rel_bad     = '0;
        for (int p = 0; p < 2; p++) begin
            if (rel_v[p]) begin
                if ((int'(rel_row[p]) < ROWS) && !free[rel_row[p]] && live[rel_row[p]][rel_slot[p]])
                    rel_ok[p] = 1'b1;
                else
                    rel_bad[p] = 1'b1;
            end
        end
    end

    // Next state: clear released slots, recycle rows that drained, then apply the grant.
    // The granted row was free pre-edge, so it can never collide with a release or recycle.
    always_comb begin
        live_nxt = live;
        free_nxt = free;
        rec_cnt  = '0;
        for (int p = 0; p < 2; p++) begin
            if (rel_ok[p]) live_nxt[rel_row[p]][rel_slot[p]] = 1'b0;
        end
        for (int r = 0; r < ROWS; r++) begin
            if (!free[r] && (live_nxt[r] == 4'b0000)) begin
                free_nxt[r] = 1'b1;
                rec_cnt     = rec_cnt + 1'b1;
            end
        end
        if (grant) begin
            free_nxt[alloc_row] = 1'b0;
            live_nxt[alloc_row] = i_alloc_mask;
        end
        cnt_nxt = free_cnt + rec_cnt - (RW+1)'(grant);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            free     <= '1;
            live     <= '0;
            free_cnt <= (RW+1)'(ROWS);
            err      <= 1'b0;
        end else if (i_flush) begin
            free     <= '1;
            live     <= '0;
            free_cnt <= (RW+1)'(ROWS);
        end else begin
            free     <= free_nxt;
            live     <= live_nxt;
            free_cnt <= cnt_nxt;
            err      <= err | (|rel_bad);
        end
    end

    a_free_cnt : assert property (@(posedge i_clk) disable iff (i_rst)
        free_cnt == ($bits(free_cnt))'($countones(free)));

endmodule

// File: tb/tb_imm_alloc.sv
// Directed bench for imm_alloc (SIZE=32: 8 rows, 3-bit row tags, 5-bit entry addresses).
// Inputs change 1 time unit after posedge; outputs are compared at the following negedge
// (combinational grant signals) or after the edge (registered state).
module tb_imm_alloc;
    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       alloc_valid;
    logic [3:0] alloc_mask;
    logic       alloc_ready;
    logic [2:0] alloc_row;
    logic       we;
    logic [7:0] waddr;
    logic       rel_valid0, rel_valid1;
    logic [4:0] rel_addr0, rel_addr1;
    logic [3:0] free_cnt;
    logic       err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_alloc #(.SIZE(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_alloc_valid(alloc_valid), .i_alloc_mask(alloc_mask),
        .o_alloc_ready(alloc_ready), .o_alloc_row(alloc_row),
        .o_we(we), .o_waddr(waddr),
        .i_rel_valid0(rel_valid0), .i_rel_valid1(rel_valid1),
        .i_rel_addr0(rel_addr0), .i_rel_addr1(rel_addr1),
        .o_free_cnt(free_cnt), .o_err(err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; flush = 0; alloc_valid = 0; alloc_mask = 0;
        rel_valid0 = 0; rel_valid1 = 0; rel_addr0 = 0; rel_addr1 = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        cyc();
        rst = 0;
    endtask

    task automatic alloc(input logic [3:0] m);
        alloc_valid = 1; alloc_mask = m;
        cyc();
        alloc_valid = 0; alloc_mask = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (free_cnt !== 4'd8) begin errors++; $display("FAIL reset_cnt: got %0d expected 8", free_cnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
        checks++; if (alloc_ready !== 1'b1 || alloc_row !== 3'd0) begin errors++; $display("FAIL reset_ready: ready %0b row %0d expected 1 row 0", alloc_ready, alloc_row); end
        checks++; if (we !== 1'b0 || waddr !== 8'h00) begin errors++; $display("FAIL reset_we: we %0b waddr %0h expected 0 00", we, waddr); end
        cyc();
    endtask

    task automatic test_fill();
        logic [7:0] exp_waddr;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            alloc_valid = 1; alloc_mask = 4'b1111;
            exp_waddr = 8'h01 << i;
            @(negedge clk);
            checks++;
            if (alloc_ready !== 1'b1 || we !== 1'b1 || alloc_row !== 3'(i) || waddr !== exp_waddr || free_cnt !== 4'(8 - i)) begin
                errors++;
                $display("FAIL fill_%0d: ready %0b we %0b row %0d waddr %0h cnt %0d expected 1 1 %0d %0h %0d",
                         i, alloc_ready, we, alloc_row, waddr, free_cnt, i, exp_waddr, 8 - i);
            end
            cyc();
        end
        @(negedge clk);
        checks++;
        if (alloc_ready !== 1'b0 || we !== 1'b0 || waddr !== 8'h00 || free_cnt !== 4'd0) begin
            errors++;
            $display("FAIL fill_full: ready %0b we %0b waddr %0h cnt %0d expected 0 0 00 0", alloc_ready, we, waddr, free_cnt);
        end
        cyc();
        idle();
    endtask

    task automatic test_partial_release();
        do_reset();
        alloc(4'b1111);
        alloc(4'b1111);
        alloc(4'b0101);
        rel_valid0 = 1; rel_addr0 = 5'd8;
        cyc();
        rel_valid0 = 0;
        checks++; if (free_cnt !== 4'd5 || alloc_row !== 3'd3) begin errors++; $display("FAIL part_first: cnt %0d row %0d expected 5 3", free_cnt, alloc_row); end
        // Last live slot of row 2 released while dispatch asks: row 3 is granted, not row 2.
        rel_valid0 = 1; rel_addr0 = 5'd10;
        alloc_valid = 1; alloc_mask = 4'b1111;
        @(negedge clk);
        checks++; if (we !== 1'b1 || alloc_row !== 3'd3 || waddr !== 8'h08) begin errors++; $display("FAIL part_grant: we %0b row %0d waddr %0h expected 1 3 08", we, alloc_row, waddr); end
        cyc();
        rel_valid0 = 0;
        @(negedge clk);
        checks++; if (free_cnt !== 4'd5 || alloc_row !== 3'd2 || waddr !== 8'h04) begin errors++; $display("FAIL part_reuse: cnt %0d row %0d waddr %0h expected 5 2 04", free_cnt, alloc_row, waddr); end
        cyc();
        idle();
        checks++; if (free_cnt !== 4'd4 || err !== 1'b0) begin errors++; $display("FAIL part_after: cnt %0d err %0b expected 4 0", free_cnt, err); end
    endtask

    task automatic test_full_recycle();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i == 5) alloc(4'b0001);
            else if (i == 6) alloc(4'b0010);
            else alloc(4'b1111);
        end
        rel_valid0 = 1; rel_addr0 = 5'd20;
        rel_valid1 = 1; rel_addr1 = 5'd25;
        alloc_valid = 1; alloc_mask = 4'b1111;
        @(negedge clk);
        checks++; if (alloc_ready !== 1'b0 || we !== 1'b0) begin errors++; $display("FAIL full_same_cycle: ready %0b we %0b expected 0 0", alloc_ready, we); end
        cyc();
        rel_valid0 = 0; rel_valid1 = 0;
        @(negedge clk);
        checks++; if (free_cnt !== 4'd2 || alloc_row !== 3'd5 || we !== 1'b1 || waddr !== 8'h20) begin errors++; $display("FAIL full_next: cnt %0d row %0d we %0b waddr %0h expected 2 5 1 20", free_cnt, alloc_row, we, waddr); end
        cyc();
        idle();
        checks++; if (free_cnt !== 4'd1 || alloc_row !== 3'd6) begin errors++; $display("FAIL full_after: cnt %0d row %0d expected 1 6", free_cnt, alloc_row); end
    endtask

    task automatic test_same_slot();
        do_reset();
        alloc(4'b0011);
        rel_valid0 = 1; rel_addr0 = 5'd0;
        rel_valid1 = 1; rel_addr1 = 5'd0;
        cyc();
        rel_valid1 = 0;
        checks++; if (err !== 1'b0 || free_cnt !== 4'd7) begin errors++; $display("FAIL same_slot: err %0b cnt %0d expected 0 7", err, free_cnt); end
        rel_addr0 = 5'd1;
        cyc();
        rel_valid0 = 0;
        checks++; if (err !== 1'b0 || free_cnt !== 4'd8) begin errors++; $display("FAIL same_row_done: err %0b cnt %0d expected 0 8", err, free_cnt); end
    endtask

    task automatic test_err();
        do_reset();
        rel_valid0 = 1; rel_addr0 = 5'd13;
        cyc();
        rel_valid0 = 0;
        checks++; if (err !== 1'b1 || free_cnt !== 4'd8) begin errors++; $display("FAIL err_set: err %0b cnt %0d expected 1 8", err, free_cnt); end
        alloc(4'b1111);
        checks++; if (err !== 1'b1 || free_cnt !== 4'd7) begin errors++; $display("FAIL err_sticky: err %0b cnt %0d expected 1 7", err, free_cnt); end
        flush = 1;
        cyc();
        flush = 0;
        checks++; if (err !== 1'b1 || free_cnt !== 4'd8) begin errors++; $display("FAIL err_flush: err %0b cnt %0d expected 1 8", err, free_cnt); end
        do_reset();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_rst: err %0b expected 0", err); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) alloc(4'b1111);
        flush = 1;
        alloc_valid = 1; alloc_mask = 4'b1111;
        rel_valid0 = 1; rel_addr0 = 5'd0;
        @(negedge clk);
        checks++; if (we !== 1'b0 || alloc_ready !== 1'b0 || waddr !== 8'h00) begin errors++; $display("FAIL flush_cycle: we %0b ready %0b waddr %0h expected 0 0 00", we, alloc_ready, waddr); end
        cyc();
        flush = 0; rel_valid0 = 0;
        @(negedge clk);
        checks++; if (free_cnt !== 4'd8 || alloc_row !== 3'd0 || we !== 1'b1 || waddr !== 8'h01) begin errors++; $display("FAIL flush_next: cnt %0d row %0d we %0b waddr %0h expected 8 0 1 01", free_cnt, alloc_row, we, waddr); end
        cyc();
        idle();
        checks++; if (err !== 1'b0 || free_cnt !== 4'd7) begin errors++; $display("FAIL flush_after: err %0b cnt %0d expected 0 7", err, free_cnt); end
        // Row 1 was busy before the flush; its slots must no longer be live.
        rel_valid0 = 1; rel_addr0 = 5'd4;
        cyc();
        rel_valid0 = 0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL flush_live_clr: err %0b expected 1", err); end
    endtask

    task automatic test_mask_zero_and_rst();
        do_reset();
        alloc_valid = 1; alloc_mask = 4'b0000;
        @(negedge clk);
        checks++; if (we !== 1'b0 || alloc_ready !== 1'b1 || waddr !== 8'h00) begin errors++; $display("FAIL mask0_we: we %0b ready %0b waddr %0h expected 0 1 00", we, alloc_ready, waddr); end
        cyc();
        alloc_valid = 0;
        checks++; if (free_cnt !== 4'd8 || alloc_row !== 3'd0) begin errors++; $display("FAIL mask0_cnt: cnt %0d row %0d expected 8 0", free_cnt, alloc_row); end
        for (int i = 0; i < 3; i++) alloc(4'b1000);
        rel_valid0 = 1; rel_addr0 = 5'd31;
        cyc();
        rel_valid0 = 0;
        checks++; if (free_cnt !== 4'd5 || err !== 1'b1) begin errors++; $display("FAIL pre_rst: cnt %0d err %0b expected 5 1", free_cnt, err); end
        rst = 1; alloc_valid = 1; alloc_mask = 4'b1111;
        cyc();
        rst = 0; alloc_valid = 0;
        checks++; if (free_cnt !== 4'd8 || err !== 1'b0 || alloc_row !== 3'd0) begin errors++; $display("FAIL mid_rst: cnt %0d err %0b row %0d expected 8 0 0", free_cnt, err, alloc_row); end
    endtask

    initial begin
        idle();
        rst = 1;
        test_reset();
        test_fill();
        test_partial_release();
        test_full_recycle();
        test_same_slot();
        test_err();
        test_flush();
        test_mask_zero_and_rst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imm_alloc.md
Name: imm_alloc

Overview:
Row allocator and write sequencer for the 4-wide immediate file (SIZE entries, SIZE/4 rows of 4 slots; entry address = {row, slot}). Dispatch presents one bundle of up to 4 immediates per cycle. The block picks the lowest free row and drives the file's write enable and one-hot row select in the same cycle. It returns the row tag to dispatch and tracks per-slot liveness. A row is recycled only once every slot written into it has been released by issue/commit; flush reclaims everything.

Parameters:
SIZE, 32, number of immediate entries; must be a multiple of 4, >= 8
ROWS, SIZE/4, derived (localparam), number of 4-slot rows
RW, $clog2(ROWS), derived (localparam), row tag width

Ports:
i_clk  input  1  clock; all state updates on posedge
i_rst  input  1  synchronous, active-high reset
i_flush  input  1  pipeline flush; reclaims all rows
i_alloc_valid  input  1  dispatch requests a row this cycle
i_alloc_mask  input  4  slots of the bundle carrying an immediate (bit k = slot k)
o_alloc_ready  output  1  a row can be granted this cycle
o_alloc_row  output  RW  granted row tag (lowest-index free row)
o_we  output  1  write enable to immediate file
o_waddr  output  ROWS  one-hot row select to immediate file
i_rel_valid0, i_rel_valid1  input  1 each  release requests, two ports
i_rel_addr0, i_rel_addr1  input  $clog2(SIZE) each  entry released, {row, slot}
o_free_cnt  output  RW+1  number of free rows
o_err  output  1  sticky: release of a slot that was not live

Behaviour:
- State: free[ROWS] bitmap; live[ROWS][4] slot bitmap; free_cnt register; err flag.
- Reset (i_rst=1 at posedge): free=all 1, live=0, o_free_cnt=ROWS, o_err=0. Reset has priority over all other inputs.
- Combinational outputs:
  - o_alloc_ready = |free & ~i_flush.
  - o_alloc_row = index of the lowest set bit of free; 0 when none is set.
  - o_we = i_alloc_valid & o_alloc_ready & (i_alloc_mask != 0).
  - o_waddr = o_we ? onehot(o_alloc_row) : 0.
  - The file latches data on the same posedge, so grant-to-write latency is 0 cycles.
- Accept: i_alloc_valid & o_alloc_ready.
  - Mask 0 is accepted as a no-op: no row consumed, o_we=0.
  - Otherwise at posedge: free[row]<=0, live[row]<=i_alloc_mask, free_cnt-1.
- Dispatch holds i_alloc_valid and the mask while o_alloc_ready=0. There is no internal queue.
- Release, per port: row=addr[high bits], slot=addr[1:0].
  - At posedge, clear live[row][slot].
  - If the slot was not live, or the row is free, set err (sticky) and change no other state.
  - Both ports naming the same slot: one clear, no error.
  - Both ports may hit the same row on different slots.
- Row recycle:
  - A row whose live mask becomes 0 through release is set free at the same posedge. It is allocatable from the next cycle (1-cycle release-to-reuse latency).
  - free_cnt increments by the number of rows recycled that cycle (0..2).
- Same-cycle alloc and release:
  - Releases never target the row being granted, because that row is free pre-edge.
  - free_cnt net = +recycled - granted, so ranges -1..+2.
  - Grant uses pre-edge free only; a row freed this cycle is not grantable.
- Flush (i_flush=1, no reset):
  - At posedge: free=all 1, live=0, free_cnt=ROWS.
  - Alloc and release inputs that cycle are ignored; o_alloc_ready=0 and o_we=0.
  - err is kept.
- Full: free_cnt=0 gives o_alloc_ready=0 and o_we=0. Empty: free_cnt=ROWS.
- Invariant: o_free_cnt == popcount(free) at all times. Verify with an assertion.

Test Plan:
- Reset then 8 accepts with mask 4'b1111 -> rows 0..7 granted in order, o_waddr 8'h01..8'h80, o_free_cnt 8->0; 9th request sees o_alloc_ready=0, o_we=0.
- Grant row 2 with mask 4'b0101; release addrs 8 then 10 on separate cycles -> row 2 stays busy after 8, free after 10. It is not grantable in the release cycle and is granted as the lowest free row the next cycle.
- Full file, same cycle: release the last live slot of row 5 and of row 6 (rel0 / rel1) plus alloc_valid=1 -> no grant that cycle. Next cycle o_free_cnt=2 and grant row 5.
- Release addr 13 when row 3 is free -> o_err=1 and stays 1 across further traffic; flush does not clear it; i_rst clears it.
- 5 rows busy, i_flush=1 with alloc_valid=1 and a valid release -> o_we=0 that cycle; next cycle o_free_cnt=8, all live=0, grant row 0.
- i_alloc_valid with mask 4'b0000 -> o_we=0, o_free_cnt unchanged; i_rst asserted mid-stream with 3 rows busy -> next cycle o_free_cnt=8, o_err=0.
